// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// rtl/hwpe_stream_tcdm_rr_arbiter.sv - round-robin NB_IN:1 TCDM arbiter with response routing
// Relies on the fixed one-cycle TCDM read latency to steer r_valid back to its requester.
module hwpe_stream_tcdm_rr_arbiter #(
   parameter int unsigned NB_IN = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 32,
   localparam int unsigned ID_W = $clog2(NB_IN)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic [NB_IN-1:0]               in_req_i,
   input  logic [NB_IN-1:0][AW-1:0]       in_add_i,
   input  logic [NB_IN-1:0]               in_wen_i,
   input  logic [NB_IN-1:0][DW/8-1:0]     in_be_i,
   input  logic [NB_IN-1:0][DW-1:0]       in_data_i,
   output logic [NB_IN-1:0]               in_gnt_o,
   output logic [NB_IN-1:0][DW-1:0]       in_r_data_o,
   output logic [NB_IN-1:0]               in_r_valid_o,
   output logic                           out_req_o,
   output logic [AW-1:0]                  out_add_o,
   output logic                           out_wen_o,
   output logic [DW/8-1:0]                out_be_o,
   output logic [DW-1:0]                  out_data_o,
   input  logic                           out_gnt_i,
   input  logic [DW-1:0]                  out_r_data_i,
   input  logic                           out_r_valid_i,
   output logic                           err_o,
   output logic [ID_W-1:0]                winner_o
);

   logic [ID_W-1:0] rr_q, rr_d;
   logic            lock_q, lock_d;
   logic [ID_W-1:0] lock_id_q, lock_id_d;
   logic            pend_q, pend_d;
   logic [ID_W-1:0] pend_id_q, pend_id_d;
   logic            err_q, err_d;

   logic            lock_act;
   logic            hs;
   logic            found_hi, found_lo;
   logic [ID_W-1:0] cand_hi, cand_lo, rr_win, win;

   // Two-pass scan: lowest requester at or above rr_q, else lowest overall (wrap).
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      cand_hi  = '0;
      cand_lo  = '0;
      for (int i = NB_IN - 1; i >= 0; i--) begin
         if (in_req_i[i]) begin
            found_lo = 1'b1;
            cand_lo  = ID_W'(i);
            if (ID_W'(i) >= rr_q) begin
               found_hi = 1'b1;
               cand_hi  = ID_W'(i);
            end
         end
      end
      rr_win = found_hi ? cand_hi : (found_lo ? cand_lo : '0);
   end

   // A lock only holds while its owner still requests; otherwise round-robin resumes.
   assign lock_act  = lock_q & in_req_i[lock_id_q];
   assign win       = lock_act ? lock_id_q : rr_win;
   assign out_req_o = |in_req_i;
   assign hs        = out_req_o & out_gnt_i;

   assign out_add_o  = out_req_o ? in_add_i[win]  : '0;
   assign out_wen_o  = out_req_o ? in_wen_i[win]  : 1'b0;
   assign out_be_o   = out_req_o ? in_be_i[win]   : '0;
   assign out_data_o = out_req_o ? in_data_i[win] : '0;
   assign winner_o   = out_req_o ? win : '0;
   assign err_o      = err_q;

   always_comb begin
      in_gnt_o = '0;
      if (hs) in_gnt_o[win] = 1'b1;
      for (int i = 0; i < NB_IN; i++) begin
         in_r_valid_o[i] = out_r_valid_i & pend_q & (pend_id_q == ID_W'(i));
         in_r_data_o[i]  = out_r_data_i;
      end
   end

   always_comb begin
      rr_d      = rr_q;
      lock_d    = 1'b0;
      lock_id_d = lock_id_q;
      pend_d    = 1'b0;
      pend_id_d = pend_id_q;
      err_d     = err_q | (pend_q != out_r_valid_i);
      if (hs) begin
         rr_d = (win == ID_W'(NB_IN - 1)) ? '0 : win + 1'b1;
         if (out_wen_o) begin
            pend_d    = 1'b1;
            pend_id_d = win;
         end
      end else if (out_req_o) begin
         lock_d    = 1'b1;
         lock_id_d = win;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q      <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         pend_q    <= 1'b0;
         pend_id_q <= '0;
         err_q     <= 1'b0;
      end else if (clear_i) begin
         rr_q      <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         pend_q    <= 1'b0;
         pend_id_q <= '0;
         err_q     <= 1'b0;
      end else begin
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         pend_q    <= pend_d;
         pend_id_q <= pend_id_d;
         err_q     <= err_d;
      end
   end

endmodule
